stream_serializer_flushable: RTL and testbench

- Downstream neighbour of the flushable spill register.
- Takes one wide word per valid/ready handshake and emits it as Ratio = InWidth/OutWidth narrow beats, least-significant slice first, on a valid/ready output stream.
- Shares the same flush_i as the upstream spill register, so a pipeline flush empties both stages in the same cycle.
- Narrow side marks the final beat of each word with last_o.

---
 rtl/stream_serializer_flushable_if.sv | 19 +
 rtl/stream_serializer_flushable.sv | 51 +++++
 tb/tb_stream_serializer_flushable.sv | 129 ++++++++++++
 3 files changed

// File: rtl/stream_serializer_flushable_if.sv
// stream_serializer_flushable_if: wide-in / narrow-out valid-ready bundle for the serializer
// Ports: valid_i/ready_o/data_i carry input words; valid_o/ready_i/data_o/last_o/beat_idx_o carry output beats.
// slave is the serializer's view, master is the view of whatever surrounds it.
interface stream_serializer_flushable_if #(
  parameter int InWidth  = 64,
  parameter int OutWidth = 16
);
  localparam int CntWidth = $clog2(InWidth / OutWidth);
  logic                valid_i;
  logic                ready_o;
  logic [InWidth-1:0]  data_i;
  logic                valid_o;
  logic                ready_i;
  logic [OutWidth-1:0] data_o;
  logic                last_o;
  logic [CntWidth-1:0] beat_idx_o;
  modport slave  (input valid_i, data_i, ready_i, output ready_o, valid_o, data_o, last_o, beat_idx_o);
  modport master (output valid_i, data_i, ready_i, input ready_o, valid_o, data_o, last_o, beat_idx_o);
endinterface

// File: rtl/stream_serializer_flushable.sv
// stream_serializer_flushable: splits each InWidth word into InWidth/OutWidth beats, LSB slice first
// Ports: clk_i, rst_ni (async, active low), flush_i (sync, drops the word in flight), s (slave view of the stream bundle).
// Optional macro STREAM_SERIALIZER_CUT_READY_EN: ready_o = !full_q, cutting the ready_i -> ready_o path at one idle cycle per word.
module stream_serializer_flushable #(
  parameter int InWidth  = 64,
  parameter int OutWidth = 16
) (
  input logic                          clk_i,
  input logic                          rst_ni,
  input logic                          flush_i,
  stream_serializer_flushable_if.slave s
);
  localparam int Ratio    = InWidth / OutWidth;
  localparam int CntWidth = $clog2(Ratio);
  if (OutWidth < 1 || InWidth % OutWidth != 0 || Ratio < 2) begin : g_bad_cfg
    $error("InWidth must be an integer multiple (>=2) of OutWidth");
  end
  logic [InWidth-1:0]  word_q, word_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                full_q, full_d;
  logic                in_hs, out_hs, last;
  assign last         = full_q && (cnt_q == CntWidth'(Ratio - 1));
  assign s.valid_o    = full_q;
  assign s.last_o     = last;
  assign s.beat_idx_o = cnt_q;
  assign s.data_o     = word_q[cnt_q*OutWidth +: OutWidth];
`ifdef STREAM_SERIALIZER_CUT_READY_EN
  assign s.ready_o    = !full_q;
`else
  assign s.ready_o    = !full_q || (last && s.ready_i);
`endif
  assign in_hs  = s.valid_i && s.ready_o && !flush_i;
  assign out_hs = full_q && s.ready_i;
  // in_hs already excludes flush, so flush simply wins over everything below.
  always_comb begin
    word_d = in_hs ? s.data_i : word_q;
    cnt_d  = (flush_i || in_hs || (out_hs && last)) ? '0 : out_hs ? cnt_q + 1'b1 : cnt_q;
    full_d = flush_i ? 1'b0 : in_hs ? 1'b1 : (out_hs && last) ? 1'b0 : full_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
    end
  end
endmodule

// File: tb/tb_stream_serializer_flushable.sv
// tb_stream_serializer_flushable: directed plus random checks of the serializer against a beat-queue model
module tb_stream_serializer_flushable;
  localparam int IW = 32;
  localparam int OW = 8;
  localparam int R  = IW / OW;
  typedef struct {
    logic [OW-1:0] d;
    logic          l;
    logic [1:0]    i;
  } beat_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int total = 0;
  int bad = 0;
  beat_t q[$];
  stream_serializer_flushable_if #(.InWidth(IW), .OutWidth(OW)) bus ();
  stream_serializer_flushable #(.InWidth(IW), .OutWidth(OW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .s(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Model's ready: the serializer can take a word when nothing is queued, or
  // (zero-bubble build) when only the final beat remains and it is leaving now.
  function automatic logic exp_ready(input logic r);
`ifdef STREAM_SERIALIZER_CUT_READY_EN
    return q.size() == 0;
`else
    return q.size() == 0 || (q.size() == 1 && r);
`endif
  endfunction
  task automatic step(input logic v, input logic [IW-1:0] d, input logic r, input logic f, output logic acc);
    logic rdy;
    bus.valid_i = v;
    bus.data_i  = d;
    bus.ready_i = r;
    flush       = f;
    #2;
    rdy = exp_ready(r);
    chk("valid_o", 32'(bus.valid_o), 32'(q.size() != 0));
    chk("ready_o", 32'(bus.ready_o), 32'(rdy));
    chk("last_o", 32'(bus.last_o), q.size() != 0 ? 32'(q[0].l) : 32'd0);
    chk("beat_idx_o", 32'(bus.beat_idx_o), q.size() != 0 ? 32'(q[0].i) : 32'd0);
    if (q.size() != 0) chk("data_o", 32'(bus.data_o), 32'(q[0].d));
    acc = v && rdy && !f;
    if (f) q.delete();
    else if (acc) begin
      q.delete();
      for (int k = 0; k < R; k++) q.push_back('{d: d[k*OW +: OW], l: (k == R - 1), i: 2'(k)});
    end else if (q.size() != 0 && r) void'(q.pop_front());
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [IW-1:0] d, input logic r);
    logic acc;
    int n = 0;
    do begin
      step(1'b1, d, r, 1'b0, acc);
      n++;
    end while (!acc && n < 12);
    chk("accept_timeout", 32'(acc), 32'd1);
  endtask
  task automatic idle(input int n, input logic r);
    logic acc;
    for (int k = 0; k < n; k++) step(1'b0, '0, r, 1'b0, acc);
  endtask
  initial begin
    logic acc;
    bus.valid_i = 1'b0;
    bus.data_i  = '0;
    bus.ready_i = 1'b1;
    #12;
    chk("rst_valid_o", 32'(bus.valid_o), 32'd0);
    chk("rst_ready_o", 32'(bus.ready_o), 32'd1);
    chk("rst_data_o", 32'(bus.data_o), 32'd0);
    chk("rst_last_o", 32'(bus.last_o), 32'd0);
    chk("rst_beat_idx_o", 32'(bus.beat_idx_o), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(32'hDDCCBBAA, 1'b1);
    idle(6, 1'b1);
    send(32'h44332211, 1'b1);
    send(32'h88776655, 1'b1);
    idle(6, 1'b1);
    send(32'hDDCCBBAA, 1'b1);
    idle(1, 1'b1);
    idle(3, 1'b0);
    idle(5, 1'b1);
    send(32'hDDCCBBAA, 1'b1);
    idle(2, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1, acc);
    idle(1, 1'b1);
    send(32'h0F0E0D0C, 1'b1);
    idle(5, 1'b1);
    send(32'h13579BDF, 1'b1);
    idle(3, 1'b1);
    step(1'b1, 32'hCAFEF00D, 1'b1, 1'b1, acc);
    idle(2, 1'b1);
    send(32'hA5A5_5A5A, 1'b1);
    idle(1, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid_o", 32'(bus.valid_o), 32'd0);
    chk("async_rst_ready_o", 32'(bus.ready_o), 32'd1);
    chk("async_rst_beat_idx_o", 32'(bus.beat_idx_o), 32'd0);
    q.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(1, 1'b1);
    send(32'h76543210, 1'b1);
    idle(5, 1'b1);
    for (int k = 0; k < 400; k++)
      step(($urandom % 4) != 0, IW'($urandom), ($urandom % 4) != 0, ($urandom % 24) == 0, acc);
    idle(8, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
